// File: rtl/quadrature_decoder_pkg.sv
// Shared types and Gray-code constants for the quadrature decoder.
// Holds the step classifier used by the decode logic.
package quadrature_decoder_pkg;

  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  // Forward order is S0 -> S1 -> S2 -> S3 -> S0; both bits flipping is illegal.
  function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_e res;
    res = STEP_NONE;
    if (prev_ab == cur_ab) begin
      res = STEP_NONE;
    end else if ((prev_ab ^ cur_ab) == 2'b11) begin
      res = STEP_ILLEGAL;
    end else begin
      case (prev_ab)
        GRAY_S0: res = (cur_ab == GRAY_S1) ? STEP_UP : STEP_DOWN;
        GRAY_S1: res = (cur_ab == GRAY_S2) ? STEP_UP : STEP_DOWN;
        GRAY_S2: res = (cur_ab == GRAY_S3) ? STEP_UP : STEP_DOWN;
        GRAY_S3: res = (cur_ab == GRAY_S0) ? STEP_UP : STEP_DOWN;
        default: res = STEP_NONE;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Configuration and status bundle between the decoder and the register bank / stream framer.
interface quadrature_decoder_if #(
  parameter int COUNTER_WIDTH = 32,
  parameter int ERR_WIDTH     = 16
);

  logic                     cfg_enable;
  logic                     cfg_invert;
  logic                     cfg_index_en;
  logic                     cfg_clear;
  logic [1:0]               ab_filt;
  logic [COUNTER_WIDTH-1:0] position;
  logic                     direction;
  logic                     step_pulse;
  logic                     error;
  logic [ERR_WIDTH-1:0]     error_count;
  logic [COUNTER_WIDTH-1:0] index_pos;
  logic                     index_pulse;

  modport master (
    input  cfg_enable, cfg_invert, cfg_index_en, cfg_clear,
    output ab_filt, position, direction, step_pulse,
    output error, error_count, index_pos, index_pulse
  );

  modport slave (
    output cfg_enable, cfg_invert, cfg_index_en, cfg_clear,
    input  ab_filt, position, direction, step_pulse,
    input  error, error_count, index_pos, index_pulse
  );

endinterface

// File: rtl/quadrature_decoder_chk.sv
// Invariants of the decoder state, kept apart from the datapath.
module quadrature_decoder_chk #(
  parameter int ERR_WIDTH = 16
) (
  input logic                 clk,
  input logic                 aresetn,
  input logic                 error,
  input logic [ERR_WIDTH-1:0] error_count,
  input logic                 primed,
  input logic                 z_level,
  input logic                 z_stable
);

  a_count_implies_flag: assert property (@(posedge clk) disable iff (!aresetn)
    (error_count != ERR_WIDTH'(0)) |-> error);

  a_primed_sticky: assert property (@(posedge clk) disable iff (!aresetn)
    primed |=> primed);

  a_z_edge_not_stable: assert property (@(posedge clk) disable iff (!aresetn)
    $rose(z_level) |-> !z_stable);

endmodule

// File: rtl/quadrature_decoder_enc_input_filter.sv
// Two-flop synchroniser plus stability filter for one asynchronous encoder pin.
// The level moves only after the synchronised pin disagrees with it for FILTER_LEN cycles in a row.
module enc_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic aresetn,
  input  logic pin,
  output logic level,
  output logic stable
);

  localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(FILTER_LEN);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             stable_r;
  logic [CNT_W-1:0] diff_cnt_r;
  logic [CNT_W-1:0] hold_cnt_r;

  // Metastability guard for the raw pin.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
    end
  end

  // Disagreement counter moves the level; agreement counter reports how long it has held.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      level_r    <= 1'b0;
      stable_r   <= 1'b0;
      diff_cnt_r <= '0;
      hold_cnt_r <= '0;
    end else if (sync2_r != level_r) begin
      hold_cnt_r <= '0;
      stable_r   <= 1'b0;
      if (diff_cnt_r == LAST_CNT) begin
        level_r    <= sync2_r;
        diff_cnt_r <= '0;
      end else begin
        diff_cnt_r <= diff_cnt_r + CNT_W'(1);
      end
    end else begin
      diff_cnt_r <= '0;
      hold_cnt_r <= (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : hold_cnt_r + CNT_W'(1);
      stable_r   <= (hold_cnt_r == HOLD_MAX);
    end
  end

  assign level  = level_r;
  assign stable = stable_r;

endmodule

// File: rtl/quadrature_decoder.sv
// A/B/Z quadrature decoder: filtered pins, 4x wrapping position, illegal-transition
// tracking and index latching, all outputs registered.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int FILTER_LEN    = 4,
  parameter int ERR_WIDTH     = 16
) (
  input  logic clk,
  input  logic aresetn,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enc_z,
  quadrature_decoder_if.master bus
);

  logic                     a_level_s;
  logic                     b_level_s;
  logic                     z_level_s;
  logic                     a_stable_s;
  logic                     b_stable_s;
  logic                     z_stable_s;
  logic [1:0]               ab_filt_s;

  logic [1:0]               prev_ab_r;
  logic                     z_prev_r;
  logic                     primed_r;
  logic [COUNTER_WIDTH-1:0] position_r;
  logic [COUNTER_WIDTH-1:0] index_pos_r;
  logic                     direction_r;
  logic                     step_pulse_r;
  logic                     index_pulse_r;
  logic                     error_r;
  logic [ERR_WIDTH-1:0]     error_count_r;

  logic [COUNTER_WIDTH-1:0] position_nxt_s;
  logic [COUNTER_WIDTH-1:0] index_pos_nxt_s;
  logic                     direction_nxt_s;
  logic                     step_pulse_nxt_s;
  logic                     index_pulse_nxt_s;
  logic                     error_nxt_s;
  logic [ERR_WIDTH-1:0]     error_count_nxt_s;

  step_e                    step_kind_s;
  logic                     step_valid_s;
  logic                     count_up_s;
  logic [COUNTER_WIDTH-1:0] pos_stepped_s;
  logic                     index_hit_s;

  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .aresetn(aresetn), .pin(enc_a), .level(a_level_s), .stable(a_stable_s)
  );
  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .aresetn(aresetn), .pin(enc_b), .level(b_level_s), .stable(b_stable_s)
  );
  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clk(clk), .aresetn(aresetn), .pin(enc_z), .level(z_level_s), .stable(z_stable_s)
  );

  assign ab_filt_s     = {b_level_s, a_level_s};
  assign step_kind_s   = decode_step(prev_ab_r, ab_filt_s);
  assign step_valid_s  = (step_kind_s == STEP_UP) || (step_kind_s == STEP_DOWN);
  assign count_up_s    = (step_kind_s == STEP_UP) ^ bus.cfg_invert;
  assign pos_stepped_s = !step_valid_s ? position_r :
                         count_up_s    ? position_r + COUNTER_WIDTH'(1) :
                                         position_r - COUNTER_WIDTH'(1);
  assign index_hit_s   = z_level_s && !z_prev_r && (ab_filt_s == GRAY_S0) && bus.cfg_index_en;

  // Next-state for counting, error tracking and index zeroing; clear dominates.
  always_comb begin
    position_nxt_s    = position_r;
    index_pos_nxt_s   = index_pos_r;
    direction_nxt_s   = direction_r;
    step_pulse_nxt_s  = 1'b0;
    index_pulse_nxt_s = 1'b0;
    error_nxt_s       = error_r;
    error_count_nxt_s = error_count_r;
    if (bus.cfg_clear) begin
      position_nxt_s    = '0;
      index_pos_nxt_s   = '0;
      error_nxt_s       = 1'b0;
      error_count_nxt_s = '0;
    end else if (primed_r && bus.cfg_enable) begin
      if (step_valid_s) begin
        position_nxt_s   = pos_stepped_s;
        direction_nxt_s  = count_up_s;
        step_pulse_nxt_s = 1'b1;
      end else if (step_kind_s == STEP_ILLEGAL) begin
        error_nxt_s = 1'b1;
        if (&error_count_r) begin
          error_count_nxt_s = error_count_r;
        end else begin
          error_count_nxt_s = error_count_r + ERR_WIDTH'(1);
        end
      end else begin
        position_nxt_s = position_r;
      end
      // index_pos captures the position including any step decoded this cycle
      if (index_hit_s) begin
        index_pos_nxt_s   = pos_stepped_s;
        position_nxt_s    = '0;
        index_pulse_nxt_s = 1'b1;
      end else begin
        index_pulse_nxt_s = 1'b0;
      end
    end else begin
      step_pulse_nxt_s = 1'b0;
    end
  end

  // State and output registers; prev_ab and z history track the filters every cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prev_ab_r     <= 2'b00;
      z_prev_r      <= 1'b0;
      primed_r      <= 1'b0;
      position_r    <= '0;
      index_pos_r   <= '0;
      direction_r   <= 1'b0;
      step_pulse_r  <= 1'b0;
      index_pulse_r <= 1'b0;
      error_r       <= 1'b0;
      error_count_r <= '0;
    end else begin
      prev_ab_r     <= ab_filt_s;
      z_prev_r      <= z_level_s;
      primed_r      <= primed_r | (a_stable_s & b_stable_s);
      position_r    <= position_nxt_s;
      index_pos_r   <= index_pos_nxt_s;
      direction_r   <= direction_nxt_s;
      step_pulse_r  <= step_pulse_nxt_s;
      index_pulse_r <= index_pulse_nxt_s;
      error_r       <= error_nxt_s;
      error_count_r <= error_count_nxt_s;
    end
  end

  assign bus.ab_filt     = ab_filt_s;
  assign bus.position    = position_r;
  assign bus.direction   = direction_r;
  assign bus.step_pulse  = step_pulse_r;
  assign bus.error       = error_r;
  assign bus.error_count = error_count_r;
  assign bus.index_pos   = index_pos_r;
  assign bus.index_pulse = index_pulse_r;

  quadrature_decoder_chk #(.ERR_WIDTH(ERR_WIDTH)) u_chk (
    .clk(clk), .aresetn(aresetn), .error(error_r), .error_count(error_count_r),
    .primed(primed_r), .z_level(z_level_s), .z_stable(z_stable_s)
  );

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench: stimulus queues expected step/index/error events, a monitor pops and compares.
module tb_quadrature_decoder;

  localparam int CW = 32;
  localparam int FL = 4;
  localparam int EW = 2;

  logic clk = 1'b0;
  logic aresetn;
  logic enc_a, enc_b, enc_z;

  quadrature_decoder_if #(.COUNTER_WIDTH(CW), .ERR_WIDTH(EW)) qd_bus ();

  quadrature_decoder #(.COUNTER_WIDTH(CW), .FILTER_LEN(FL), .ERR_WIDTH(EW)) dut (
    .clk(clk), .aresetn(aresetn), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .bus(qd_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [CW-1:0] pos; logic dir; } step_exp_t;
  typedef struct packed { logic [CW-1:0] ipos; logic [CW-1:0] pos; } idx_exp_t;

  step_exp_t      step_q[$];
  idx_exp_t       idx_q[$];
  logic [EW-1:0]  err_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int hold);
    {enc_b, enc_a} = ab;
    cycles(hold);
  endtask

  task automatic exp_step(input logic [CW-1:0] p, input logic d);
    step_q.push_back('{pos: p, dir: d});
  endtask

  task automatic pulse_clear();
    qd_bus.cfg_clear = 1'b1;
    cycles(1);
    qd_bus.cfg_clear = 1'b0;
    cycles(1);
  endtask

  // Monitor: every strobe or error increment must match the head of its queue.
  initial begin
    logic [EW-1:0] err_seen;
    step_exp_t se;
    idx_exp_t  ie;
    err_seen = '0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        err_seen = '0;
      end else begin
        if (qd_bus.step_pulse) begin
          if (step_q.size() == 0) begin
            checks++;
            $display("FAIL step_unexpected: step_pulse with no expected step, position=%0h", qd_bus.position);
          end else begin
            se = step_q.pop_front();
            check("step_position", qd_bus.position, se.pos);
            check("step_direction", qd_bus.direction, se.dir);
          end
        end
        if (qd_bus.index_pulse) begin
          if (idx_q.size() == 0) begin
            checks++;
            $display("FAIL index_unexpected: index_pulse with no expected index, index_pos=%0h", qd_bus.index_pos);
          end else begin
            ie = idx_q.pop_front();
            check("index_pos", qd_bus.index_pos, ie.ipos);
            check("index_position", qd_bus.position, ie.pos);
          end
        end
        if (qd_bus.error_count > err_seen) begin
          if (err_q.size() == 0) begin
            checks++;
            $display("FAIL error_unexpected: error_count=%0d with no expected error", qd_bus.error_count);
          end else begin
            check("error_count", qd_bus.error_count, err_q.pop_front());
            check("error_flag", qd_bus.error, 1'b1);
          end
        end
        err_seen = qd_bus.error_count;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] seen_ab;
    aresetn = 1'b0;
    {enc_b, enc_a} = 2'b11;
    enc_z = 1'b0;
    qd_bus.cfg_enable   = 1'b0;
    qd_bus.cfg_invert   = 1'b0;
    qd_bus.cfg_index_en = 1'b0;
    qd_bus.cfg_clear    = 1'b0;

    // 1: reset values and pin-to-ab_filt latency with pins at 11
    cycles(3);
    check("reset_ab_filt", qd_bus.ab_filt, 2'b00);
    check("reset_position", qd_bus.position, 32'h0);
    aresetn = 1'b1;
    cycles(5);
    check("ab_filt_cycle5", qd_bus.ab_filt, 2'b00);
    cycles(1);
    check("ab_filt_cycle6", qd_bus.ab_filt, 2'b11);
    cycles(12);
    check("prime_no_error", qd_bus.error, 1'b0);
    check("prime_position", qd_bus.position, 32'h0);

    // 2: forward, reverse, inverted forward
    drive_ab(2'b10, 10);
    drive_ab(2'b00, 10);
    check("disabled_no_count", qd_bus.position, 32'h0);
    qd_bus.cfg_enable = 1'b1;
    cycles(2);
    exp_step(32'd1, 1'b1); drive_ab(2'b01, 10);
    exp_step(32'd2, 1'b1); drive_ab(2'b11, 10);
    exp_step(32'd3, 1'b1); drive_ab(2'b10, 10);
    exp_step(32'd4, 1'b1); drive_ab(2'b00, 10);
    check("fwd_position", qd_bus.position, 32'd4);
    exp_step(32'd3, 1'b0); drive_ab(2'b10, 10);
    exp_step(32'd2, 1'b0); drive_ab(2'b11, 10);
    exp_step(32'd1, 1'b0); drive_ab(2'b01, 10);
    exp_step(32'd0, 1'b0); drive_ab(2'b00, 10);
    check("rev_position", qd_bus.position, 32'd0);
    qd_bus.cfg_invert = 1'b1;
    exp_step(32'hFFFF_FFFF, 1'b0); drive_ab(2'b01, 10);
    exp_step(32'hFFFF_FFFE, 1'b0); drive_ab(2'b11, 10);
    exp_step(32'hFFFF_FFFD, 1'b0); drive_ab(2'b10, 10);
    exp_step(32'hFFFF_FFFC, 1'b0); drive_ab(2'b00, 10);
    check("inv_position", qd_bus.position, 32'hFFFF_FFFC);
    qd_bus.cfg_invert = 1'b0;

    // 3: 3-cycle glitch filtered, 4-cycle pulse passes
    pulse_clear();
    check("clear_position", qd_bus.position, 32'h0);
    enc_a = 1'b1;
    cycles(3);
    enc_a = 1'b0;
    seen_ab = 2'b00;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      seen_ab = seen_ab | qd_bus.ab_filt;
    end
    check("glitch3_ab_filt", seen_ab, 2'b00);
    check("glitch3_position", qd_bus.position, 32'h0);
    exp_step(32'd1, 1'b1);
    enc_a = 1'b1;
    cycles(10);
    check("pulse4_ab_filt", qd_bus.ab_filt, 2'b01);
    exp_step(32'd0, 1'b0); drive_ab(2'b00, 10);

    // 4: illegal transitions and saturation (ERR_WIDTH=2 saturates at 3)
    err_q.push_back(2'd1); drive_ab(2'b11, 10);
    check("illegal_error", qd_bus.error, 1'b1);
    check("illegal_position", qd_bus.position, 32'h0);
    err_q.push_back(2'd2); drive_ab(2'b00, 10);
    err_q.push_back(2'd3); drive_ab(2'b11, 10);
    drive_ab(2'b00, 10);
    check("err_saturated", qd_bus.error_count, 2'd3);
    check("err_sat_position", qd_bus.position, 32'h0);

    // 5: index at 00 zeroes position; Z rise at 01 does nothing
    pulse_clear();
    check("clear_error", qd_bus.error, 1'b0);
    check("clear_error_count", qd_bus.error_count, 2'd0);
    exp_step(32'd1, 1'b1); drive_ab(2'b01, 10);
    exp_step(32'd2, 1'b1); drive_ab(2'b11, 10);
    exp_step(32'd3, 1'b1); drive_ab(2'b10, 10);
    exp_step(32'd4, 1'b1); drive_ab(2'b00, 10);
    exp_step(32'd5, 1'b1); drive_ab(2'b01, 10);
    qd_bus.cfg_enable = 1'b0;
    drive_ab(2'b00, 10);
    qd_bus.cfg_enable   = 1'b1;
    qd_bus.cfg_index_en = 1'b1;
    cycles(2);
    check("pre_index_position", qd_bus.position, 32'd5);
    idx_q.push_back('{ipos: 32'd5, pos: 32'd0});
    enc_z = 1'b1;
    cycles(12);
    check("index_hold_pos", qd_bus.index_pos, 32'd5);
    enc_z = 1'b0;
    cycles(10);
    exp_step(32'd1, 1'b1); drive_ab(2'b01, 10);
    enc_z = 1'b1;
    cycles(12);
    check("no_index_position", qd_bus.position, 32'd1);
    check("no_index_pos", qd_bus.index_pos, 32'd5);
    enc_z = 1'b0;
    cycles(10);

    // 6: wrap below zero, clear beats a coincident step, async reset
    pulse_clear();
    exp_step(32'hFFFF_FFFF, 1'b0); drive_ab(2'b00, 10);
    check("wrap_position", qd_bus.position, 32'hFFFF_FFFF);
    {enc_b, enc_a} = 2'b01;
    repeat (6) @(posedge clk);
    @(negedge clk);
    qd_bus.cfg_clear = 1'b1;
    @(negedge clk);
    qd_bus.cfg_clear = 1'b0;
    cycles(8);
    check("clear_step_position", qd_bus.position, 32'h0);
    check("clear_step_direction", qd_bus.direction, 1'b0);
    exp_step(32'd1, 1'b1); drive_ab(2'b11, 10);
    err_q.push_back(2'd1); drive_ab(2'b00, 10);
    err_q.push_back(2'd2); drive_ab(2'b11, 10);
    check("pre_reset_position", qd_bus.position, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("areset_position", qd_bus.position, 32'h0);
    check("areset_error", qd_bus.error, 1'b0);
    check("areset_error_count", qd_bus.error_count, 2'd0);
    check("areset_ab_filt", qd_bus.ab_filt, 2'b00);
    check("areset_direction", qd_bus.direction, 1'b0);
    check("areset_index_pos", qd_bus.index_pos, 32'h0);
    cycles(3);
    aresetn = 1'b1;
    cycles(20);
    check("post_reset_ab_filt", qd_bus.ab_filt, 2'b11);
    check("post_reset_error", qd_bus.error, 1'b0);

    check("step_q_drained", step_q.size(), 0);
    check("idx_q_drained", idx_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
